id_ex_hazard_reg: RTL and testbench
===================================

# id_ex_hazard_reg

ID/EX pipeline register and load-use hazard unit: the consuming end of the `ID_EX` bundle that instruction decode drives combinationally each cycle. It captures the decode bundle on every clock edge. It inserts a one-cycle bubble on a load-use hazard and back-pressures the fetch stage. It also squashes the decoded instruction on a taken branch/jump from execute, freezes on a downstream hold, and keeps saturating performance counters.

## Interface
Parameters:
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high; sampled on `clk`.
- `idex_in`  in  `ID_EX`  decode bundle for the instruction currently in ID.
- `valid_in`  in  1  `idex_in` holds a real instruction.
- `flush`  in  1  taken branch/jal/jalr resolved in EX this cycle; squash ID.
- `hold`  in  1  downstream (MEM) stall; freeze this register.
- `idex_out`  out  `ID_EX`  registered bundle to execute.
- `valid_out`  out  1  `idex_out` is a real instruction.
- `pc_write`  out  1  PC may update this cycle.
- `ifid_write`  out  1  IF/ID register may update this cycle.
- `stall_cnt`  out  `CNT_W`  load-use bubbles inserted.
- `flush_cnt`  out  `CNT_W`  flush bubbles inserted.

## Operation
- `lu_hazard` is combinational. It is 1 when all of these hold:
  - `valid_out`
  - `idex_out.memread`
  - `idex_out.rd != 0`
  - `valid_in`
  - `idex_out.rd == idex_in.rs1` or `idex_out.rd == idex_in.rs2`
- Both sources are compared regardless of opcode. A false stall on `rs2` for I-type instructions is accepted.
- "Bubble" means `idex_out <= '0` (all fields, including every control bit) and `valid_out <= 0`.
- Per-edge action, in strict priority order:
  1. `reset`: `idex_out <= '0`, `valid_out <= 0`, both counters `<= 0`.
  2. `hold`: all registers keep their value and the counters do not change. EX keeps `flush` asserted for as long as it is held, so a flush is never lost.
  3. `flush`: bubble; `flush_cnt` increments.
  4. `lu_hazard`: bubble; `stall_cnt` increments.
  5. Otherwise: `idex_out <= idex_in`, `valid_out <= valid_in`.
- Counters saturate at all-ones and never wrap.
- `pc_write` and `ifid_write` are combinational and equal in every cycle:
  - 1 during `reset`.
  - 0 if `hold`.
  - 1 if `flush`, because fetch must redirect; IF/ID flushing is owned by fetch.
  - 0 if `lu_hazard`.
  - 1 otherwise.
- A load-use stall lasts exactly one cycle: the bubble clears `valid_out`, so `lu_hazard` drops on the following cycle. Back-to-back loads with a dependency produce one bubble each.
- `rd == 0` never causes a stall.

## Timing
- Latency: `idex_in` → `idex_out` is 1 cycle.
- `pc_write`/`ifid_write` respond in the same cycle as their inputs, with no register stage.
- Reset values:
  - `idex_out` = all zero, `valid_out` = 0.
  - `stall_cnt` = 0, `flush_cnt` = 0.
  - `pc_write` = 1, `ifid_write` = 1.
- Reset asserted mid-stall or mid-hold: the next edge clears everything, and no counter increments on that edge.
- `flush` and `lu_hazard` in the same cycle: flush wins. Only `flush_cnt` increments, and `pc_write` = 1.
- `hold` together with `flush` or `lu_hazard`: hold wins, nothing changes, and both write enables are 0.
- `valid_in` = 0: no hazard is possible, and the captured bundle passes through with `valid_out` = 0.

## Test plan
- Reset: drive `reset` = 1 for 2 cycles with random `idex_in`, then release. Required after release: `idex_out` = 0, `valid_out` = 0, both counters = 0, `pc_write` = `ifid_write` = 1.
- Pass-through: `idex_in` = {rd=5, regwrite=1, imm=0x10}, `valid_in` = 1. Required: `idex_out` equals it one cycle later and `valid_out` = 1.
- Load-use stall:
  - Cycle 0: `lw` rd=7.
  - Cycle 1: `add` rs1=7 is presented; required in cycle 1: `pc_write` = 0, `ifid_write` = 0.
  - Cycle 2: required `idex_out` = 0, `valid_out` = 0, `stall_cnt` = 1; `add` is held in ID and captured on the next edge.
  - Repeat with rd=0. Required: no stall.
- Flush vs hazard: assert `flush` in the same cycle as a load-use hazard. Required: bubble, `flush_cnt` = 1, `stall_cnt` = 0, `pc_write` = 1.
- Hold: set `idex_out` = {rd=3}, then assert `hold` for 3 cycles with `flush` = 1 and a changing `idex_in`. Required:
  - During hold: `idex_out` stays {rd=3}, counters do not change, `pc_write` = 0.
  - First edge after `hold` drops with `flush` still 1: bubble.
- Saturation: preload `stall_cnt` to 0xFFFFFFFE via repeated hazards (or force), then create 3 hazards. Required: `stall_cnt` = 0xFFFFFFFF and it stays there.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch squash,
// downstream hold and saturating bubble counters.

package id_ex_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        alusrc;
      logic        memread;
      logic        memwrite;
      logic        regwrite;
      logic        memtoreg;
      logic        branch;
      logic        jump;
   } id_ex_t;

   localparam int ID_EX_W = $bits(id_ex_t);
endpackage

module id_ex_hazard_reg
   import id_ex_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ID_EX_W-1:0] idex_in,
   input  logic               valid_in,
   input  logic               flush,
   input  logic               hold,
   output logic [ID_EX_W-1:0] idex_out,
   output logic               valid_out,
   output logic               pc_write,
   output logic               ifid_write,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   id_ex_t           inBundle;
   id_ex_t           out_q, out_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
   logic             luHazard;
   logic             writeEn;

   assign inBundle = id_ex_t'(idex_in);

   // Both sources are compared regardless of opcode; a spurious rs2 match
   // on I-type instructions only costs one extra bubble.
   assign luHazard = valid_q && out_q.memread && (out_q.rd != 5'd0) && valid_in &&
                     ((out_q.rd == inBundle.rs1) || (out_q.rd == inBundle.rs2));

   always_comb begin
      out_d      = out_q;
      valid_d    = valid_q;
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      writeEn    = 1'b1;
      if (reset) begin
         writeEn = 1'b1;
      end else if (hold) begin
         writeEn = 1'b0;
      end else if (flush) begin
         // Fetch must still advance to redirect, so the enables stay high.
         out_d      = '0;
         valid_d    = 1'b0;
         flushCnt_d = (flushCnt_q == '1) ? flushCnt_q : flushCnt_q + CNT_W'(1);
      end else if (luHazard) begin
         out_d      = '0;
         valid_d    = 1'b0;
         stallCnt_d = (stallCnt_q == '1) ? stallCnt_q : stallCnt_q + CNT_W'(1);
         writeEn    = 1'b0;
      end else begin
         out_d   = inBundle;
         valid_d = valid_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q      <= '0;
         valid_q    <= 1'b0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         out_q      <= out_d;
         valid_q    <= valid_d;
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign idex_out   = out_q;
   assign valid_out  = valid_q;
   assign pc_write   = writeEn;
   assign ifid_write = writeEn;
   assign stall_cnt  = stallCnt_q;
   assign flush_cnt  = flushCnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: a driver issues stimulus and pushes
// expected results from a rule-level model, a monitor pops and compares.

module tb_id_ex_hazard_reg;
   import id_ex_pkg::*;

   localparam int SMALL_W = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic [ID_EX_W-1:0] idexIn;
   logic               validIn;
   logic               flushIn;
   logic               holdIn;
   logic [ID_EX_W-1:0] idexOut, idexOutS;
   logic               validOut, validOutS;
   logic               pcWrite, pcWriteS;
   logic               ifidWrite, ifidWriteS;
   logic [31:0]        stallCnt, flushCnt;
   logic [SMALL_W-1:0] stallCntS, flushCntS;

   always #5 clk = ~clk;

   id_ex_hazard_reg #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .idex_in(idexIn), .valid_in(validIn),
      .flush(flushIn), .hold(holdIn), .idex_out(idexOut), .valid_out(validOut),
      .pc_write(pcWrite), .ifid_write(ifidWrite),
      .stall_cnt(stallCnt), .flush_cnt(flushCnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   id_ex_hazard_reg #(.CNT_W(SMALL_W)) dutSmall (
      .clk(clk), .reset(reset), .idex_in(idexIn), .valid_in(validIn),
      .flush(flushIn), .hold(holdIn), .idex_out(idexOutS), .valid_out(validOutS),
      .pc_write(pcWriteS), .ifid_write(ifidWriteS),
      .stall_cnt(stallCntS), .flush_cnt(flushCntS)
   );

   typedef struct {
      logic        pcw;
      id_ex_t      out;
      logic        valid;
      logic [31:0] st;
      logic [31:0] fl;
      int          stS;
      int          flS;
   } exp_t;

   exp_t expQ[$];

   int     checks = 0;
   int     failures = 0;
   bit     driverDone = 0;

   id_ex_t      mOut = '0;
   logic        mValid = 0;
   longint      mSt = 0, mFl = 0;
   int          mStS = 0, mFlS = 0;
   localparam longint MAX32 = 64'hFFFF_FFFF;
   localparam int     MAXS  = (1 << SMALL_W) - 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic vin, input logic fl,
                                input logic hd, input id_ex_t b);
      exp_t e;
      bit   hz;
      hz = mValid && mOut.memread && (mOut.rd != 0) && vin &&
           ((mOut.rd == b.rs1) || (mOut.rd == b.rs2));
      e.pcw = rst ? 1'b1 : hd ? 1'b0 : fl ? 1'b1 : hz ? 1'b0 : 1'b1;
      if (rst) begin
         mOut = '0; mValid = 0; mSt = 0; mFl = 0; mStS = 0; mFlS = 0;
      end else if (hd) begin
      end else if (fl) begin
         mOut = '0; mValid = 0;
         mFl  = (mFl + 1 > MAX32) ? MAX32 : mFl + 1;
         mFlS = (mFlS + 1 > MAXS) ? MAXS : mFlS + 1;
      end else if (hz) begin
         mOut = '0; mValid = 0;
         mSt  = (mSt + 1 > MAX32) ? MAX32 : mSt + 1;
         mStS = (mStS + 1 > MAXS) ? MAXS : mStS + 1;
      end else begin
         mOut = b; mValid = vin;
      end
      e.out = mOut; e.valid = mValid; e.st = mSt[31:0]; e.fl = mFl[31:0];
      e.stS = mStS; e.flS = mFlS;
      reset = rst; validIn = vin; flushIn = fl; holdIn = hd; idexIn = b;
      expQ.push_back(e);
      @(posedge clk);
      #2;
   endtask

   function automatic id_ex_t mk(input int rd, input int rs1, input int rs2,
                                 input bit memread, input bit regwrite, input int imm);
      id_ex_t b;
      b = '0;
      b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
      b.memread = memread; b.regwrite = regwrite; b.imm = 32'(imm);
      return b;
   endfunction

   function automatic id_ex_t rnd();
      id_ex_t b;
      b = id_ex_t'({$urandom, $urandom, $urandom});
      b.rd  = 5'($urandom_range(0, 7));
      b.rs1 = 5'($urandom_range(0, 7));
      b.rs2 = 5'($urandom_range(0, 7));
      return b;
   endfunction

   // Monitor: write enables are checked mid-cycle, registered state after the edge.
   initial begin
      exp_t e;
      forever begin
         wait (expQ.size() > 0);
         e = expQ[0];
         @(negedge clk);
         checkOutput("pc_write", 128'(pcWrite), 128'(e.pcw));
         checkOutput("ifid_write", 128'(ifidWrite), 128'(e.pcw));
         checkOutput("pc_write_small", 128'(pcWriteS), 128'(e.pcw));
         @(posedge clk);
         #1;
         checkOutput("idex_out", 128'(idexOut), 128'(e.out));
         checkOutput("valid_out", 128'(validOut), 128'(e.valid));
         checkOutput("stall_cnt", 128'(stallCnt), 128'(e.st));
         checkOutput("flush_cnt", 128'(flushCnt), 128'(e.fl));
         checkOutput("stall_cnt_small", 128'(stallCntS), 128'(e.stS));
         checkOutput("flush_cnt_small", 128'(flushCntS), 128'(e.flS));
         void'(expQ.pop_front());
      end
   end

   // Driver: directed scenarios first, then randomized traffic.
   initial begin
      reset = 1; validIn = 0; flushIn = 0; holdIn = 0; idexIn = '0;
      @(posedge clk);
      #2;
      applyStimulus(1, 1, 0, 0, rnd());
      applyStimulus(1, 1, 0, 0, rnd());
      applyStimulus(0, 1, 0, 0, mk(5, 0, 0, 0, 1, 'h10));
      applyStimulus(0, 1, 0, 0, mk(7, 1, 2, 1, 1, 0));
      applyStimulus(0, 1, 0, 0, mk(8, 7, 3, 0, 1, 0));
      applyStimulus(0, 1, 0, 0, mk(8, 7, 3, 0, 1, 0));
      applyStimulus(0, 1, 0, 0, mk(0, 1, 2, 1, 0, 0));
      applyStimulus(0, 1, 0, 0, mk(8, 0, 0, 0, 1, 0));
      applyStimulus(0, 1, 0, 0, mk(9, 1, 2, 1, 1, 0));
      applyStimulus(0, 1, 1, 0, mk(4, 9, 9, 0, 1, 0));
      applyStimulus(0, 1, 0, 0, mk(3, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1, 1, 1, rnd());
      applyStimulus(0, 1, 1, 0, rnd());
      applyStimulus(0, 0, 0, 0, mk(1, 1, 1, 1, 0, 0));
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, 0, 0, mk(1, 0, 0, 1, 1, 0));
         applyStimulus(0, 1, 0, 0, mk(2, 1, 0, 0, 1, 0));
      end
      for (int i = 0; i < 10; i++)
         applyStimulus(0, 1, 1, 0, rnd());
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, rnd());
      end
      driverDone = 1;
   end

   initial begin
      int budget;
      budget = 0;
      wait (driverDone);
      while (expQ.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #3;
      if (expQ.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: %0d items left, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
